// File: rtl/div_sequencer_if.sv
// Handshake and divider-bus bundle for div_sequencer.
// master: the sequencer side; slave: the producer/consumer/divider side.
interface div_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             div_bgn;
  logic [WIDTH-1:0] div_ibusa;
  logic [WIDTH-1:0] div_ibusb;
  logic             div_stop;
  logic [WIDTH-1:0] div_obus;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_dbz;
  logic             out_ovf;
  logic             out_tmo;
  logic             busy;

  modport master (
    input  in_valid, in_dividend, in_divisor, div_stop, div_obus, out_ready,
    output in_ready, div_bgn, div_ibusa, div_ibusb,
           out_valid, out_quot, out_rem, out_dbz, out_ovf, out_tmo, busy
  );

  modport slave (
    output in_valid, in_dividend, in_divisor, div_stop, div_obus, out_ready,
    input  in_ready, div_bgn, div_ibusa, div_ibusb,
           out_valid, out_quot, out_rem, out_dbz, out_ovf, out_tmo, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// Front-end and result stage for the non-restoring divider: operand FIFO,
// launch with a single begin pulse, capture of the serialized rem/quot words,
// local resolution of divide-by-zero and -2^(W-1)/-1, and a WAIT watchdog.
//
// state  | meaning
// IDLE   | waiting for an operand pair in the FIFO
// LAUNCH | operands latched; bypass cases resolved or div_bgn pulsed
// WAIT   | divider running; collecting output words, watchdog counting down
// RESULT | result held on out_*, waiting for out_ready
module div_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 31
) (
  input logic              CLK,
  input logic              RESET,
  div_sequencer_if.master  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fa_q [DEPTH];
  logic [WIDTH-1:0] fa_d [DEPTH];
  logic [WIDTH-1:0] fb_q [DEPTH];
  logic [WIDTH-1:0] fb_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] h0_q, h0_d, h1_q, h1_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic             stop_q, stop_d;
  logic [TW-1:0]    wdog_q, wdog_d;
  logic             push, pop, stop_rise, div_bgn;

  // No bypass: a full FIFO refuses even when the head is popped this cycle.
  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (state_q == IDLE) && (count_q != '0);
  assign stop_rise    = bus.div_stop & ~stop_q;

  // FIFO storage, pointers and occupancy
  always_comb begin
    fa_d     = fa_q;
    fb_d     = fb_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fa_d[wr_ptr_q] = bus.in_dividend;
      fb_d[wr_ptr_q] = bus.in_divisor;
      wr_ptr_d       = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Sequencer next state, result capture and the watchdog down-counter
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    wdog_d  = wdog_q;
    stop_d  = bus.div_stop;
    div_bgn = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          opa_d   = fa_q[rd_ptr_q];
          opb_d   = fb_q[rd_ptr_q];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (opb_q == '0) begin
          quot_d  = '0;
          rem_d   = opa_q;
          dbz_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESULT;
        end else if ((opa_q == MOST_NEG) && (opb_q == MINUS_ONE)) begin
          quot_d  = MOST_NEG;
          rem_d   = '0;
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESULT;
        end else begin
          div_bgn = 1'b1;
          wdog_d  = TW'(TIMEOUT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        h1_d = bus.div_obus;
        h0_d = h1_q;
        // The divider drives rem first, then quot, then raises stop.
        if (stop_rise) begin
          quot_d  = h1_q;
          rem_d   = h0_q;
          valid_d = 1'b1;
          state_d = RESULT;
        end else if (wdog_q == '0) begin
          quot_d  = '0;
          rem_d   = '0;
          tmo_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESULT;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards queued operands and any in-flight divide
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      fa_q     <= '{default: '0};
      fb_q     <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      h0_q     <= '0;
      h1_q     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      stop_q   <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      stop_q   <= stop_d;
      wdog_q   <= wdog_d;
    end
  end

  assign bus.div_bgn   = div_bgn;
  assign bus.div_ibusa = opa_q;
  assign bus.div_ibusb = opb_q;
  assign bus.out_valid = valid_q;
  assign bus.out_quot  = quot_q;
  assign bus.out_rem   = rem_q;
  assign bus.out_dbz   = dbz_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_tmo   = tmo_q;
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: reset values, divider path, bypass cases,
// watchdog, output backpressure and reset during a divide.
module tb_div_sequencer;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 31;

  logic CLK = 1'b0;
  logic RESET;
  int   n_vec = 0;
  int   n_err = 0;
  int   bgn_cnt = 0;

  always #5 CLK = ~CLK;

  div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // div_bgn is combinational from registered state; sample once per cycle
  always @(negedge CLK) if (bus.div_bgn === 1'b1) bgn_cnt++;

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    @(negedge CLK);
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_accept: in_ready got %b, expected 1", bus.in_ready);
    end else begin
      @(posedge CLK);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (bus.out_valid === 1'b1) break;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [19:0] res();
    return {bus.out_valid, bus.out_quot, bus.out_rem, bus.out_dbz, bus.out_ovf, bus.out_tmo};
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    n_vec++;
    if ({bus.in_ready, bus.div_bgn, bus.busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, expected 100", {bus.in_ready, bus.div_bgn, bus.busy});
    end
    n_vec++;
    if ({bus.div_ibusa, bus.div_ibusb} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_ibus: got %h, expected 0000", {bus.div_ibusa, bus.div_ibusb});
    end
    n_vec++;
    if (res() !== 20'h0) begin
      n_err++;
      $display("FAIL reset_result: got %h, expected 00000", res());
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    n_vec++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: got %b, expected 100", {bus.in_ready, bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_divide();
    int  b0 = bgn_cnt;
    bit  stable = 1'b1;
    bus.div_stop = 1'b0;
    push(8'd100, 8'd7);
    @(negedge CLK);
    n_vec++;
    if (bus.div_bgn !== 1'b0) begin
      n_err++;
      $display("FAIL div_bgn_early: got %b, expected 0", bus.div_bgn);
    end
    @(negedge CLK);
    n_vec++;
    if ({bus.div_bgn, bus.div_ibusa, bus.div_ibusb} !== {1'b1, 8'd100, 8'd7}) begin
      n_err++;
      $display("FAIL div_launch: got %h, expected %h",
               {bus.div_bgn, bus.div_ibusa, bus.div_ibusb}, {1'b1, 8'd100, 8'd7});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if ({bus.div_ibusa, bus.div_ibusb} !== {8'd100, 8'd7} || bus.div_bgn !== 1'b0) stable = 1'b0;
      case (i)
        0: bus.div_obus = 8'd2;
        1: bus.div_obus = 8'd14;
        default: begin
          bus.div_stop = 1'b1;
          bus.div_obus = 8'hA5;
        end
      endcase
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL div_wait_stable: got %b, expected 1", stable);
    end
    @(negedge CLK);
    n_vec++;
    if (res() !== {1'b1, 8'd14, 8'd2, 3'b000}) begin
      n_err++;
      $display("FAIL div_result: got %h, expected %h", res(), {1'b1, 8'd14, 8'd2, 3'b000});
    end
    n_vec++;
    if (bgn_cnt - b0 !== 1) begin
      n_err++;
      $display("FAIL div_bgn_count: got %0d, expected 1", bgn_cnt - b0);
    end
    ack();
    bus.div_stop = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL div_ack_clear: got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_div_by_zero();
    int b0 = bgn_cnt;
    bit early = 1'b0;
    push(8'hD3, 8'h00);
    repeat (2) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b0) early = 1'b1;
    end
    @(negedge CLK);
    n_vec++;
    if ({early, res()} !== {1'b0, 1'b1, 8'h00, 8'hD3, 3'b100}) begin
      n_err++;
      $display("FAIL dbz_result: got %h, expected %h", {early, res()}, {1'b0, 1'b1, 8'h00, 8'hD3, 3'b100});
    end
    n_vec++;
    if (bgn_cnt !== b0) begin
      n_err++;
      $display("FAIL dbz_no_bgn: got %0d pulses, expected 0", bgn_cnt - b0);
    end
    ack();
    n_vec++;
    if ({bus.out_valid, bus.out_dbz} !== 2'b00) begin
      n_err++;
      $display("FAIL dbz_ack_clear: got %b, expected 00", {bus.out_valid, bus.out_dbz});
    end
  endtask

  task automatic test_overflow();
    int b0 = bgn_cnt;
    push(8'h80, 8'hFF);
    repeat (3) @(negedge CLK);
    n_vec++;
    if (res() !== {1'b1, 8'h80, 8'h00, 3'b010}) begin
      n_err++;
      $display("FAIL ovf_result: got %h, expected %h", res(), {1'b1, 8'h80, 8'h00, 3'b010});
    end
    n_vec++;
    if (bgn_cnt !== b0) begin
      n_err++;
      $display("FAIL ovf_no_bgn: got %0d pulses, expected 0", bgn_cnt - b0);
    end
    ack();
  endtask

  task automatic test_watchdog();
    bit early = 1'b0;
    bus.div_stop = 1'b1;
    bus.div_obus = 8'h3C;
    push(8'd50, 8'd3);
    repeat (2) @(negedge CLK);
    n_vec++;
    if (bus.div_bgn !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_launch: got %b, expected 1", bus.div_bgn);
    end
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b0) early = 1'b1;
    end
    n_vec++;
    if (early !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_early: got %b, expected 0", early);
    end
    @(negedge CLK);
    n_vec++;
    if (res() !== {1'b1, 8'h00, 8'h00, 3'b001}) begin
      n_err++;
      $display("FAIL wdog_result: got %h, expected %h", res(), {1'b1, 8'h00, 8'h00, 3'b001});
    end
    ack();
    bus.div_stop = 1'b0;
  endtask

  task automatic test_backpressure();
    bit held = 1'b1;
    bus.out_ready = 1'b0;
    push(8'h0B, 8'h00);
    push(8'h80, 8'hFF);
    push(8'h16, 8'h00);
    @(negedge CLK);
    n_vec++;
    if ({bus.in_ready, bus.busy} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_full: got %b, expected 01", {bus.in_ready, bus.busy});
    end
    repeat (6) begin
      @(negedge CLK);
      if (bus.in_ready !== 1'b0 || res() !== {1'b1, 8'h00, 8'h0B, 3'b100}) held = 1'b0;
    end
    n_vec++;
    if (held !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold: got %b, expected 1", held);
    end
    wait_valid();
    n_vec++;
    if (res() !== {1'b1, 8'h00, 8'h0B, 3'b100}) begin
      n_err++;
      $display("FAIL bp_first: got %h, expected %h", res(), {1'b1, 8'h00, 8'h0B, 3'b100});
    end
    ack();
    wait_valid();
    n_vec++;
    if (res() !== {1'b1, 8'h80, 8'h00, 3'b010}) begin
      n_err++;
      $display("FAIL bp_second: got %h, expected %h", res(), {1'b1, 8'h80, 8'h00, 3'b010});
    end
    ack();
    wait_valid();
    n_vec++;
    if (res() !== {1'b1, 8'h00, 8'h16, 3'b100}) begin
      n_err++;
      $display("FAIL bp_third: got %h, expected %h", res(), {1'b1, 8'h00, 8'h16, 3'b100});
    end
    ack();
    @(negedge CLK);
    n_vec++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL bp_drained: got %b, expected 100", {bus.in_ready, bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_reset_in_wait();
    int b0;
    bit seen = 1'b0;
    bus.div_stop = 1'b0;
    bus.div_obus = 8'h00;
    push(8'd100, 8'd7);
    repeat (3) @(negedge CLK);
    push(8'd9, 8'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      n_err++;
      $display("FAIL rst_wait_flags: got %b, expected 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
    n_vec++;
    if ({bus.div_ibusa, bus.div_ibusb} !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_wait_ibus: got %h, expected 0000", {bus.div_ibusa, bus.div_ibusb});
    end
    b0 = bgn_cnt;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 0) bus.div_obus = 8'd2;
      if (i == 1) bus.div_obus = 8'd14;
      if (i == 2) bus.div_stop = 1'b1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    bus.div_stop = 1'b0;
    n_vec++;
    if ({seen, bgn_cnt - b0} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL rst_wait_no_result: got seen=%b pulses=%0d, expected seen=0 pulses=0",
               seen, bgn_cnt - b0);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.div_stop    = 1'b0;
    bus.div_obus    = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_divide();
    test_div_by_zero();
    test_overflow();
    test_watchdog();
    test_backpressure();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
